// File: rtl/rggen_access_arbiter_pkg.sv
// Shared types and constants for the register-block access arbiter.
package rggen_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPONSE
    } rggen_arbiter_state;

    typedef logic [1:0] rggen_status_t;

    localparam rggen_status_t RGGEN_STATUS_OK      = 2'b00;
    localparam rggen_status_t RGGEN_STATUS_SLVERR  = 2'b10;
    localparam rggen_status_t RGGEN_STATUS_TIMEOUT = 2'b11;

    // Bits needed to index/count 'count' values, never less than one.
    function automatic int rggen_width(int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/rggen_access_arbiter_if.sv
// Host-side request/response and downstream access signals of the arbiter.
interface rggen_access_arbiter_if
    import rggen_access_arbiter_pkg::*;
#(
    parameter int REQUESTERS    = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic [REQUESTERS-1:0]                    i_request_valid;
    logic [REQUESTERS-1:0]                    i_request_write;
    logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0] i_request_address;
    logic [REQUESTERS-1:0][BUS_WIDTH-1:0]     i_request_write_data;
    logic [REQUESTERS-1:0][BUS_WIDTH-1:0]     i_request_write_mask;
    logic [REQUESTERS-1:0]                    o_request_ready;
    logic [REQUESTERS-1:0]                    o_response_valid;
    logic [REQUESTERS-1:0]                    i_response_ready;
    rggen_status_t                            o_response_status;
    logic [BUS_WIDTH-1:0]                     o_response_read_data;
    logic                                     o_access_valid;
    logic                                     o_access_write;
    logic [ADDRESS_WIDTH-1:0]                 o_access_address;
    logic [BUS_WIDTH-1:0]                     o_access_write_data;
    logic [BUS_WIDTH-1:0]                     o_access_write_mask;
    logic                                     i_access_ready;
    rggen_status_t                            i_access_status;
    logic [BUS_WIDTH-1:0]                     i_access_read_data;

    // slave: the arbiter; master: requesters plus downstream register block
    modport slave (
        input  i_request_valid, i_request_write, i_request_address,
               i_request_write_data, i_request_write_mask, i_response_ready,
               i_access_ready, i_access_status, i_access_read_data,
        output o_request_ready, o_response_valid, o_response_status,
               o_response_read_data, o_access_valid, o_access_write,
               o_access_address, o_access_write_data, o_access_write_mask
    );

    modport master (
        output i_request_valid, i_request_write, i_request_address,
               i_request_write_data, i_request_write_mask, i_response_ready,
               i_access_ready, i_access_status, i_access_read_data,
        input  o_request_ready, o_response_valid, o_response_status,
               o_response_read_data, o_access_valid, o_access_write,
               o_access_address, o_access_write_data, o_access_write_mask
    );

endinterface

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rggen_round_robin_selector
    import rggen_access_arbiter_pkg::*;
#(
    parameter  int REQUESTERS  = 2,
    localparam int INDEX_WIDTH = rggen_width(REQUESTERS)
)(
    input  logic [REQUESTERS-1:0]  i_request,
    input  logic [INDEX_WIDTH-1:0] i_last_grant,
    output logic [REQUESTERS-1:0]  o_select,
    output logic                   o_any_request
);
    logic [REQUESTERS-1:0] upper;
    logic [REQUESTERS-1:0] candidate;

    // Requests above last_grant win first; otherwise wrap to the lowest index.
    always_comb begin
        upper = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            upper[i] = i_request[i] && (i > int'(i_last_grant));
        end
        candidate     = (|upper) ? upper : i_request;
        o_select      = candidate & (~candidate + 1'b1);
        o_any_request = |i_request;
    end

endmodule

// File: rtl/rggen_access_arbiter.sv
// Round-robin arbiter sharing one register-block access port among requesters.
module rggen_access_arbiter
    import rggen_access_arbiter_pkg::*;
#(
    parameter int REQUESTERS     = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 0
)(
    input logic                   i_clk,
    input logic                   i_rst_n,
    rggen_access_arbiter_if.slave bus
);
    localparam int INDEX_WIDTH = rggen_width(REQUESTERS);
    localparam int COUNT_WIDTH = rggen_width(TIMEOUT_CYCLES + 1);

    rggen_arbiter_state     state;
    rggen_arbiter_state     state_next;
    logic [INDEX_WIDTH-1:0] last_grant;
    logic [INDEX_WIDTH-1:0] select_index;
    logic [REQUESTERS-1:0]  select;
    logic                   any_request;
    logic [COUNT_WIDTH-1:0] count;
    logic                   accept;
    logic                   start;
    logic                   complete;
    logic                   time_out;
    logic                   handshake;

    rggen_round_robin_selector #(
        .REQUESTERS (REQUESTERS)
    ) u_selector (
        .i_request     (bus.i_request_valid),
        .i_last_grant  (last_grant),
        .o_select      (select),
        .o_any_request (any_request)
    );

    always_comb begin
        select_index = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (select[i]) select_index = INDEX_WIDTH'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // IDLE spans two cycles per grant: the decision edge raises the ready
    // pulse, and the edge closing the pulse is the handshake that starts ACCESS.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start      = 1'b0;
        complete   = 1'b0;
        time_out   = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.o_request_ready) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end else if (any_request) begin
                    accept = 1'b1;
                end
            end
            ACCESS: begin
                if (bus.i_access_ready) begin
                    complete   = 1'b1;
                    state_next = RESPONSE;
                end else if ((TIMEOUT_CYCLES > 0) &&
                             (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1))) begin
                    time_out   = 1'b1;
                    state_next = RESPONSE;
                end
            end
            RESPONSE: begin
                if (bus.i_response_ready[last_grant]) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant              <= INDEX_WIDTH'(REQUESTERS - 1);
            count                   <= '0;
            bus.o_request_ready     <= '0;
            bus.o_access_valid      <= 1'b0;
            bus.o_access_write      <= 1'b0;
            bus.o_access_address    <= '0;
            bus.o_access_write_data <= '0;
            bus.o_access_write_mask <= '0;
        end else begin
            bus.o_request_ready <= accept ? select : '0;
            if (accept) last_grant <= select_index;
            if (start) begin
                bus.o_access_valid      <= 1'b1;
                bus.o_access_write      <= bus.i_request_write[last_grant];
                bus.o_access_address    <= bus.i_request_address[last_grant];
                bus.o_access_write_data <= bus.i_request_write_data[last_grant];
                bus.o_access_write_mask <= bus.i_request_write[last_grant]
                                         ? bus.i_request_write_mask[last_grant] : '0;
                count                   <= '0;
            end else if (complete || time_out) begin
                bus.o_access_valid <= 1'b0;
            end else if (state == ACCESS) begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_response_valid     <= '0;
            bus.o_response_status    <= RGGEN_STATUS_OK;
            bus.o_response_read_data <= '0;
        end else if (complete) begin
            bus.o_response_valid[last_grant] <= 1'b1;
            // 01 (exokay-style) carries no meaning for requesters; report OK.
            bus.o_response_status    <= (bus.i_access_status == 2'b01)
                                      ? RGGEN_STATUS_OK : bus.i_access_status;
            bus.o_response_read_data <= bus.o_access_write ? '0 : bus.i_access_read_data;
        end else if (time_out) begin
            bus.o_response_valid[last_grant] <= 1'b1;
            bus.o_response_status    <= RGGEN_STATUS_TIMEOUT;
            bus.o_response_read_data <= '0;
        end else if (handshake) begin
            bus.o_response_valid <= '0;
        end
    end

endmodule

// File: doc/rggen_access_arbiter.md
# rggen_access_arbiter

Round-robin arbiter that shares one register-block access port between REQUESTERS host-side requesters (for example a CPU bridge and a debug port). It sits in front of the generated register block and its bit fields. It accepts one request at a time, drives a single downstream access, and returns the response to the granted requester. The outstanding access has an optional timeout.

## Interface
- REQUESTERS, default 2: number of requesters; must be ≥ 2.
- ADDRESS_WIDTH, default 16: byte address width.
- BUS_WIDTH, default 32: data width.
- TIMEOUT_CYCLES, default 0: downstream wait limit; 0 disables the timeout.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_request_valid  input  [REQUESTERS]  request pending, per requester.
- i_request_write  input  [REQUESTERS]  1 = write, 0 = read.
- i_request_address  input  [REQUESTERS][ADDRESS_WIDTH]  access address.
- i_request_write_data  input  [REQUESTERS][BUS_WIDTH]  write data.
- i_request_write_mask  input  [REQUESTERS][BUS_WIDTH]  bitwise write mask.
- o_request_ready  output  [REQUESTERS]  one-cycle accept pulse.
- o_response_valid  output  [REQUESTERS]  response pending.
- i_response_ready  input  [REQUESTERS]  response consumed.
- o_response_status  output  2  response status: 00 OK, 10 SLVERR, 11 TIMEOUT.
- o_response_read_data  output  BUS_WIDTH  read data.
- o_access_valid, o_access_write  output  1  downstream request and direction.
- o_access_address  output  ADDRESS_WIDTH  downstream address.
- o_access_write_data, o_access_write_mask  output  BUS_WIDTH  downstream write data and mask.
- i_access_ready  input  1  downstream completion.
- i_access_status  input  2  downstream status.
- i_access_read_data  input  BUS_WIDTH  downstream read data.

## Operation
- States:
  - IDLE: any i_request_valid set → select a requester, go to ACCESS.
  - ACCESS: i_access_ready → go to RESPONSE; timeout → go to RESPONSE.
  - RESPONSE: i_response_ready[grant] → go to IDLE.
- Selection: round-robin. Search starts at last_grant+1 modulo REQUESTERS. After reset last_grant = REQUESTERS-1, so requester 0 wins first.
- In the accept cycle (IDLE with a request):
  - o_request_ready[sel] = 1 for exactly that cycle;
  - write, address, write data and write mask are registered;
  - grant and last_grant are updated.
- For a read, the registered o_access_write_mask is forced to '0.
- ACCESS:
  - o_access_valid = 1 and all access fields are held stable until completion.
  - The fields are driven from the registered copies, not from the live inputs.
- Completion (i_access_ready = 1 while o_access_valid = 1):
  - i_access_status is registered into o_response_status, with 01 mapped to 00;
  - i_access_read_data is registered into o_response_read_data (writes: register '0).
- Timeout (TIMEOUT_CYCLES > 0):
  - The wait counter increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 without ready, o_access_valid drops in the next cycle.
  - Status = 11, read data = '0.
  - Ready arriving in that same cycle takes priority over the timeout.
- RESPONSE:
  - Only o_response_valid[grant] = 1; status and data are held until i_response_ready[grant].
  - i_response_ready of requesters that are not granted is ignored.
- Requests that are not accepted stay pending; the arbiter never drops them.
- Mid-operation reset: return immediately to IDLE with all outputs at reset values. No response is generated for the aborted access.

## Timing
- Reset values:
  - o_request_ready, o_response_valid, o_access_valid = 0;
  - o_access_write = 0; all data, address and mask outputs = '0; o_response_status = 00;
  - state = IDLE; last_grant = REQUESTERS-1; counter = 0.
- Latency: accept at cycle T, o_access_valid at T+1, earliest o_response_valid at T+2.
- A response handshake at cycle R returns to IDLE at R+1; the next accept is no earlier than R+1. One transaction is in flight at most.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It is cleared on entering ACCESS.

## Structure
- Package rggen_access_arbiter_pkg:
  - state enum rggen_arbiter_state (IDLE, ACCESS, RESPONSE);
  - status constants RGGEN_STATUS_OK = 2'b00, RGGEN_STATUS_SLVERR = 2'b10, RGGEN_STATUS_TIMEOUT = 2'b11.
- Sub-module rggen_round_robin_selector (combinational):
  - inputs: request vector and last_grant;
  - outputs: one-hot select and an any-request flag.
  - It is reusable by other shared-resource blocks.

## Test plan
- Single read, REQUESTERS = 2:
  - stimulus: req0 read 0x0010, downstream ready one cycle after valid, status 00, data 0xA5A5_0001;
  - required: ready0 at T, access_valid at T+1 to T+2, response_valid0 at T+3 with data 0xA5A5_0001, status 00.
- Fairness: both requesters continuously valid for 4 transactions → grants 0, 1, 0, 1; each o_request_ready is a single-cycle pulse.
- Write masking:
  - stimulus: req1 write 0x0004, data 0xFFFF_FFFF, mask 0x0000_00FF;
  - required: access fields match exactly and are stable through 3 stall cycles; response data = '0.
- Timeout, TIMEOUT_CYCLES = 4, downstream never ready: access_valid for 4 cycles, then response status 11, data '0. A variant with ready in the 4th cycle gives status 00.
- Response backpressure: hold i_response_ready0 low for 5 cycles → response stays valid with stable status and data. A pending req1 is not accepted until after the handshake.
- Reset asserted during ACCESS → all outputs 0 at once. After release, requester 0 wins the next arbitration.
